// File: rtl/run_pkg.sv
// Shared types and program table for the run sequencer.
// Base/end addresses are core PC values for each selectable program.
package run_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} runState_t;

  localparam int NPROG = 3;

  localparam int PROG0_BASE = 0;
  localparam int PROG0_END  = 6;
  localparam int PROG1_BASE = 460;
  localparam int PROG1_END  = 800;
  localparam int PROG2_BASE = 10;
  localparam int PROG2_END  = 450;

  function automatic logic progValid(input logic [1:0] p);
    return int'(p) < NPROG;
  endfunction

  function automatic int progBase(input logic [1:0] p);
    case (p)
      2'd0:    return PROG0_BASE;
      2'd1:    return PROG1_BASE;
      2'd2:    return PROG2_BASE;
      default: return 0;
    endcase
  endfunction

  function automatic int progEndAddr(input logic [1:0] p);
    case (p)
      2'd0:    return PROG0_END;
      2'd1:    return PROG1_END;
      2'd2:    return PROG2_END;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/run_watchdog.sv
// Saturating RUN-cycle counter; tmoHit flags that this cycle's increment reaches TMO.
// Count updates one cycle after en; no backpressure (clr has priority over en).
module run_watchdog #(
  parameter int             CW  = 16,
  parameter logic [CW-1:0]  TMO = '1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tmoHit
);

  logic [CW-1:0] countInc;

  assign countInc = (count == '1) ? count : count + CW'(1);
  assign tmoHit   = en && (countInc == TMO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= countInc;
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Host run controller: holds the core, loads the program base, releases it and watches PC for the end.
// go -> busy next cycle; end match -> done next cycle; host_go outside IDLE is dropped, not queued.
module run_sequencer
  import run_pkg::*;
#(
  parameter int            D      = 10,
  parameter int            CW     = 16,
  parameter int            SETTLE = 2,
  parameter logic [CW-1:0] TMO    = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_go,
  input  logic [1:0]    host_prog,
  input  logic          host_ack,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          err,
  output logic [CW-1:0] cycles,
  output logic          core_start,
  output logic [D-1:0]  core_target,
  input  logic [D-1:0]  core_pc
);

  localparam int SW = $clog2(SETTLE + 1);

  runState_t       state;
  logic [1:0]      progReg;
  logic [SW-1:0]   settleCnt;
  logic [D-1:0]    progEnd;
  logic            wdClr;
  logic            wdEn;
  logic            tmoHit;

  assign progEnd = D'(progEndAddr(progReg));
  assign wdClr   = (state == IDLE) && host_go;
  assign wdEn    = (state == RUN);

  run_watchdog #(
    .CW  (CW),
    .TMO (TMO)
  ) uWatchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (wdClr),
    .en     (wdEn),
    .count  (cycles),
    .tmoHit (tmoHit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      progReg     <= 2'd0;
      settleCnt   <= '0;
      core_start  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      err         <= 1'b0;
      core_target <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (host_go) begin
            progReg <= host_prog;
            timeout <= 1'b0;
            if (progValid(host_prog)) begin
              core_target <= D'(progBase(host_prog));
              err         <= 1'b0;
              settleCnt   <= SW'(SETTLE - 1);
              busy        <= 1'b1;
              state       <= LOAD;
            end else begin
              // Invalid select: report straight away, the core is never released.
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        LOAD: begin
          if (settleCnt == '0) begin
            core_start <= 1'b0;
            state      <= RUN;
          end else begin
            settleCnt <= settleCnt - SW'(1);
          end
        end
        RUN: begin
          // An end match outranks a watchdog hit landing on the same cycle.
          if (core_pc >= progEnd || tmoHit) begin
            timeout    <= !(core_pc >= progEnd);
            core_start <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (host_ack) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: three instances (default TMO, TMO=20, TMO=7) each with a PC model.
module tb_run_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  prog;
  logic [2:0]  go, ack, busy, done, tmo, err, cst;
  logic [15:0] cyc [3];
  logic [9:0]  tgt [3];
  logic [9:0]  pc  [3];
  logic [2:0]  stuck;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_sequencer uDut (
    .clk(clk), .reset(reset), .host_go(go[0]), .host_prog(prog), .host_ack(ack[0]),
    .busy(busy[0]), .done(done[0]), .timeout(tmo[0]), .err(err[0]), .cycles(cyc[0]),
    .core_start(cst[0]), .core_target(tgt[0]), .core_pc(pc[0])
  );

  run_sequencer #(.TMO(16'd20)) uDut20 (
    .clk(clk), .reset(reset), .host_go(go[1]), .host_prog(prog), .host_ack(ack[1]),
    .busy(busy[1]), .done(done[1]), .timeout(tmo[1]), .err(err[1]), .cycles(cyc[1]),
    .core_start(cst[1]), .core_target(tgt[1]), .core_pc(pc[1])
  );

  run_sequencer #(.TMO(16'd7)) uDut7 (
    .clk(clk), .reset(reset), .host_go(go[2]), .host_prog(prog), .host_ack(ack[2]),
    .busy(busy[2]), .done(done[2]), .timeout(tmo[2]), .err(err[2]), .cycles(cyc[2]),
    .core_start(cst[2]), .core_target(tgt[2]), .core_pc(pc[2])
  );

  // Core PC model: loads the target while held, otherwise counts up (or sits at 5 when stuck).
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (cst[i])        pc[i] <= tgt[i];
      else if (stuck[i]) pc[i] <= 10'd5;
      else               pc[i] <= pc[i] + 10'd1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic doAck(input int k);
    ack[k] = 1'b1;
    @(posedge clk); #1;
    ack[k] = 1'b0;
  endtask

  // Issue go on instance k, then wait for done counting busy cycles and released cycles.
  task automatic runProg(input int k, input logic [1:0] p, input bit pulse,
                         output int nBusy, output int nRel, output int lat, output bit expired);
    prog  = p;
    go[k] = 1'b1;
    @(posedge clk); #1;
    go[k] = 1'b0;
    nBusy = 0; nRel = 0; lat = 0; expired = 1'b0;
    while (!done[k]) begin
      if (busy[k]) nBusy++;
      if (!cst[k]) nRel++;
      if (pulse && lat == 40) go[k] = 1'b1;
      if (pulse && lat == 42) go[k] = 1'b0;
      if (lat > 2000) begin
        expired = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [1:0] prog;
    bit         pulseGo;
    int         expCycles;
    int         expTmo;
    int         expErr;
    int         expTarget;
    int         expBusy;
    int         expRel;
    int         expLat;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int nBusy, nRel, lat;
    bit expired;

    vecs[0] = '{2'd0, 1'b0, 7,   0, 0, 0,   9,   7,   9};
    vecs[1] = '{2'd2, 1'b1, 441, 0, 0, 10,  443, 441, 443};
    vecs[2] = '{2'd3, 1'b0, 0,   0, 1, 10,  0,   0,   0};
    vecs[3] = '{2'd1, 1'b0, 341, 0, 0, 460, 343, 341, 343};

    reset = 1'b0;
    go    = '0;
    ack   = '0;
    prog  = 2'd0;
    stuck = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    check("rst core_start", int'(cst[0]), 1);
    check("rst busy", int'(busy[0]), 0);
    check("rst done", int'(done[0]), 0);
    check("rst cycles", int'(cyc[0]), 0);
    check("rst core_target", int'(tgt[0]), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle busy", int'(busy[0]), 0);
    check("idle done", int'(done[0]), 0);

    for (int v = 0; v < 4; v++) begin
      runProg(0, vecs[v].prog, vecs[v].pulseGo, nBusy, nRel, lat, expired);
      check($sformatf("v%0d wait bound", v), int'(expired), 0);
      check($sformatf("v%0d done", v), int'(done[0]), 1);
      check($sformatf("v%0d busy in done", v), int'(busy[0]), 0);
      check($sformatf("v%0d cycles", v), int'(cyc[0]), vecs[v].expCycles);
      check($sformatf("v%0d timeout", v), int'(tmo[0]), vecs[v].expTmo);
      check($sformatf("v%0d err", v), int'(err[0]), vecs[v].expErr);
      check($sformatf("v%0d core_target", v), int'(tgt[0]), vecs[v].expTarget);
      check($sformatf("v%0d busy cycles", v), nBusy, vecs[v].expBusy);
      check($sformatf("v%0d released cycles", v), nRel, vecs[v].expRel);
      check($sformatf("v%0d done latency", v), lat, vecs[v].expLat);
      if (v < 3) begin
        doAck(0);
        check($sformatf("v%0d done after ack", v), int'(done[0]), 0);
        check($sformatf("v%0d core_start after ack", v), int'(cst[0]), 1);
      end
    end

    // Ack and go together in DONE: go must be ignored.
    prog   = 2'd0;
    go[0]  = 1'b1;
    ack[0] = 1'b1;
    @(posedge clk); #1;
    go[0]  = 1'b0;
    ack[0] = 1'b0;
    check("ack+go done", int'(done[0]), 0);
    check("ack+go busy", int'(busy[0]), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("ack+go stays idle", int'(busy[0]) + int'(done[0]), 0);
    end
    check("ack+go cycles held", int'(cyc[0]), 341);

    // Fresh run from IDLE clears cycles on acceptance.
    prog  = 2'd0;
    go[0] = 1'b1;
    @(posedge clk); #1;
    go[0] = 1'b0;
    check("fresh busy", int'(busy[0]), 1);
    check("fresh cycles cleared", int'(cyc[0]), 0);
    check("fresh core_target", int'(tgt[0]), 0);
    lat = 0;
    while (!done[0] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("fresh done", int'(done[0]), 1);
    check("fresh cycles", int'(cyc[0]), 7);
    doAck(0);

    // Watchdog: PC stuck at 5 with TMO=20.
    runProg(1, 2'd0, 1'b0, nBusy, nRel, lat, expired);
    check("tmo20 wait bound", int'(expired), 0);
    check("tmo20 done", int'(done[1]), 1);
    check("tmo20 timeout", int'(tmo[1]), 1);
    check("tmo20 cycles", int'(cyc[1]), 20);
    check("tmo20 latency", lat, 22);
    doAck(1);

    // Match and TMO=7 land on the same cycle: match wins.
    runProg(2, 2'd0, 1'b0, nBusy, nRel, lat, expired);
    check("tmo7 wait bound", int'(expired), 0);
    check("tmo7 done", int'(done[2]), 1);
    check("tmo7 timeout", int'(tmo[2]), 0);
    check("tmo7 cycles", int'(cyc[2]), 7);
    doAck(2);

    // Reset dropped asynchronously mid-RUN.
    prog  = 2'd2;
    go[0] = 1'b1;
    @(posedge clk); #1;
    go[0] = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("pre-rst released", int'(cst[0]), 0);
    reset = 1'b0;
    #1;
    check("mid rst core_start", int'(cst[0]), 1);
    check("mid rst busy", int'(busy[0]), 0);
    check("mid rst done", int'(done[0]), 0);
    check("mid rst cycles", int'(cyc[0]), 0);
    check("mid rst core_target", int'(tgt[0]), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post rst idle", int'(busy[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
